// File: rtl/cntr_cmd_driver.sv
// Command-driven stimulus source for an up/down counter.
// Expands queued HOLD/LOAD/UP/DOWN commands and checks the counter against a model.
module cntr_cmd_driver #(
    parameter int WIDTH      = 8,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdData,
    input  logic [LEN_W-1:0] CmdLen,
    input  logic             CheckEn,
    output logic             Enable,
    output logic             Load,
    output logic             UpDown,
    output logic [WIDTH-1:0] InData,
    input  logic [WIDTH-1:0] OutData,
    output logic [WIDTH-1:0] ExpData,
    output logic             Mismatch,
    output logic             Busy,
    output logic             Done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    cmd_t             mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             en_q, en_d, ld_q, ld_d, ud_q, ud_d, done_q, done_d;
    logic [WIDTH-1:0] in_q, in_d, exp_q, exp_d;
    logic             mm_q, mm_d;

    logic             full, empty, push, pop, issue;
    cmd_t             head;
    logic [LEN_W-1:0] first_len;

    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign CmdReady = Reset & ~full;
    assign push     = CmdValid & CmdReady;
    assign head     = mem_q[rd_q];

    // LOAD is always a single cycle; a zero length still issues once.
    assign first_len = (head.op == OP_LOAD || head.len == '0)
                       ? LEN_W'(1) : head.len;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = '{op: op_e'(CmdOp), data: CmdData, len: CmdLen};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        en_d    = en_q;
        ld_d    = ld_q;
        ud_d    = ud_q;
        in_d    = in_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: issue = ~empty;
            EXEC: begin
                if (rem_q == LEN_W'(1)) begin
                    if (!empty) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                        rem_d   = '0;
                        en_d    = 1'b0;
                        ld_d    = 1'b0;
                    end
                end else begin
                    rem_d  = rem_q - LEN_W'(1);
                    done_d = (rem_q == LEN_W'(2));
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            pop     = 1'b1;
            state_d = EXEC;
            rem_d   = first_len;
            done_d  = (first_len == LEN_W'(1));
            unique case (head.op)
                OP_HOLD: begin
                    en_d = 1'b0;
                    ld_d = 1'b0;
                end
                OP_LOAD: begin
                    en_d = 1'b1;
                    ld_d = 1'b1;
                    in_d = head.data;
                end
                OP_UP: begin
                    en_d = 1'b1;
                    ld_d = 1'b0;
                    ud_d = 1'b1;
                end
                OP_DOWN: begin
                    en_d = 1'b1;
                    ld_d = 1'b0;
                    ud_d = 1'b0;
                end
                default: begin
                    en_d = 1'b0;
                    ld_d = 1'b0;
                end
            endcase
        end
    end

    // Model samples the same registered controls the counter sees.
    always_comb begin
        exp_d = exp_q;
        if (en_q) begin
            if (ld_q) begin
                exp_d = in_q;
            end else if (ud_q) begin
                exp_d = exp_q + WIDTH'(1);
            end else begin
                exp_d = exp_q - WIDTH'(1);
            end
        end
        mm_d = mm_q | (CheckEn & (OutData != exp_q));
    end

    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            rem_q   <= '0;
            en_q    <= 1'b0;
            ld_q    <= 1'b0;
            ud_q    <= 1'b0;
            done_q  <= 1'b0;
            in_q    <= '0;
            exp_q   <= '0;
            mm_q    <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            ld_q    <= ld_d;
            ud_q    <= ud_d;
            done_q  <= done_d;
            in_q    <= in_d;
            exp_q   <= exp_d;
            mm_q    <= mm_d;
        end
    end

    assign Enable   = en_q;
    assign Load     = ld_q;
    assign UpDown   = ud_q;
    assign InData   = in_q;
    assign ExpData  = exp_q;
    assign Mismatch = mm_q;
    assign Done     = done_q;
    assign Busy     = ~empty | (state_q == EXEC);

endmodule

// File: tb/tb_cntr_cmd_driver.sv
// Bench for cntr_cmd_driver: counter stub, command table and Done-driven scoreboard.
module tb_cntr_cmd_driver;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] len;
        logic       en;
        logic       ld;
        logic       ud;
        logic [7:0] in;
        logic [7:0] exp;
        int         runs;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CmdValid = 1'b0;
    logic       CmdReady;
    logic [1:0] CmdOp = 2'b00;
    logic [7:0] CmdData = 8'h00;
    logic [7:0] CmdLen = 8'h00;
    logic       CheckEn = 1'b1;
    logic       Enable, Load, UpDown, Mismatch, Busy, Done;
    logic [7:0] InData, OutData, ExpData;

    logic [7:0] cnt;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    int   checks = 0;
    int   failures = 0;
    int   runs = 0;
    vec_t sb[$];
    vec_t e;
    vec_t tbl[10];
    vec_t fv[6];

    cntr_cmd_driver #(.WIDTH(8), .LEN_W(8), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdData(CmdData), .CmdLen(CmdLen), .CheckEn(CheckEn),
        .Enable(Enable), .Load(Load), .UpDown(UpDown), .InData(InData),
        .OutData(OutData), .ExpData(ExpData), .Mismatch(Mismatch),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Counter stub driven by the DUT controls.
    always @(posedge Clk) begin
        if (!Reset) cnt <= 8'h00;
        else if (Enable) cnt <= Load ? InData : (UpDown ? cnt + 8'd1 : cnt - 8'd1);
    end
    assign OutData = force_en ? force_val : cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d, input logic [7:0] l,
                                input logic en, input logic ld, input logic ud,
                                input logic [7:0] in, input logic [7:0] ex, input int r);
        vec_t v;
        v.op = op; v.data = d; v.len = l; v.en = en; v.ld = ld; v.ud = ud;
        v.in = in; v.exp = ex; v.runs = r;
        return v;
    endfunction

    // At each Done pulse, compare the last issue cycle against the oldest record.
    always @(negedge Clk) begin
        if (!Reset) begin
            runs = 0;
        end else begin
            if (Enable) runs++;
            if (Done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: Done with no expected command");
                end else begin
                    e = sb.pop_front();
                    chk("sb_ctl", {Enable, Load, UpDown, InData, ExpData},
                        {e.en, e.ld, e.ud, e.in, e.exp});
                    chk("sb_runs", runs, e.runs);
                end
                runs = 0;
            end
        end
    end

    task automatic push(input vec_t v, input bit track);
        bit ok;
        ok = 1'b0;
        CmdOp = v.op; CmdData = v.data; CmdLen = v.len; CmdValid = 1'b1;
        if (track) sb.push_back(v);
        for (int k = 0; k < 100 && !ok; k++) begin
            ok = CmdReady;
            @(posedge Clk); #1;
        end
        CmdValid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_timeout: op %0d got not-accepted required accepted", v.op);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600 && Busy; k++) begin
            @(posedge Clk); #1;
        end
        chk("idle_timeout", Busy, 0);
    endtask

    initial begin
        tbl[0] = mk(2'b01, 8'h10, 8'd0, 1, 1, 0, 8'h10, 8'h00, 1);
        tbl[1] = mk(2'b10, 8'h00, 8'd5, 1, 0, 1, 8'h10, 8'h14, 5);
        tbl[2] = mk(2'b01, 8'h01, 8'd0, 1, 1, 1, 8'h01, 8'h15, 1);
        tbl[3] = mk(2'b11, 8'h00, 8'd3, 1, 0, 0, 8'h01, 8'hFF, 3);
        tbl[4] = mk(2'b00, 8'h00, 8'd0, 0, 0, 0, 8'h01, 8'hFE, 0);
        tbl[5] = mk(2'b10, 8'h00, 8'd0, 1, 0, 1, 8'h01, 8'hFE, 1);
        tbl[6] = mk(2'b10, 8'h00, 8'd2, 1, 0, 1, 8'h01, 8'h00, 2);
        tbl[7] = mk(2'b00, 8'h00, 8'd3, 0, 0, 1, 8'h01, 8'h01, 0);
        tbl[8] = mk(2'b01, 8'hFF, 8'd7, 1, 1, 1, 8'hFF, 8'h01, 1);
        tbl[9] = mk(2'b10, 8'h00, 8'd1, 1, 0, 1, 8'hFF, 8'hFF, 1);
        fv[0]  = mk(2'b00, 8'h00, 8'd20, 0, 0, 1, 8'hFF, 8'h00, 0);
        fv[1]  = mk(2'b01, 8'h80, 8'd0, 1, 1, 1, 8'h80, 8'h00, 1);
        fv[2]  = mk(2'b10, 8'h00, 8'd3, 1, 0, 1, 8'h80, 8'h82, 3);
        fv[3]  = mk(2'b11, 8'h00, 8'd1, 1, 0, 0, 8'h80, 8'h83, 1);
        fv[4]  = mk(2'b00, 8'h00, 8'd1, 0, 0, 0, 8'h80, 8'h82, 0);
        fv[5]  = mk(2'b10, 8'h00, 8'd2, 1, 0, 1, 8'h80, 8'h83, 2);

        // Reset held for three edges.
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", CmdReady, 0);
        chk("rst_outs", {Enable, Load, UpDown, Done, Mismatch, Busy, InData, ExpData}, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_ready", CmdReady, 1);
        chk("post_rst_outs", {Enable, Load, UpDown, Done, Mismatch, Busy, InData, ExpData}, 0);

        // First command latency and LOAD -> UP with no bubble.
        sb.push_back(tbl[0]);
        CmdOp = tbl[0].op; CmdData = tbl[0].data; CmdLen = tbl[0].len; CmdValid = 1'b1;
        @(posedge Clk); #1;
        chk("lat_c1", {Enable, Load}, 0);
        sb.push_back(tbl[1]);
        CmdOp = tbl[1].op; CmdData = tbl[1].data; CmdLen = tbl[1].len;
        @(posedge Clk); #1;
        chk("lat_c2", {Enable, Load, InData}, {1'b1, 1'b1, 8'h10});
        CmdValid = 1'b0;
        @(posedge Clk); #1;
        chk("up_nogap", {Enable, Load, UpDown}, 3'b101);

        for (int i = 2; i < 10; i++) push(tbl[i], 1'b1);
        wait_idle();
        chk("tbl_final", {ExpData, OutData, Mismatch}, {8'h00, 8'h00, 1'b0});

        // Fill the FIFO behind a long HOLD; the fifth waits for a pop.
        push(fv[0], 1'b1);
        for (int i = 1; i < 5; i++) push(fv[i], 1'b1);
        chk("full_ready", CmdReady, 0);
        CmdOp = fv[5].op; CmdData = fv[5].data; CmdLen = fv[5].len; CmdValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk); #1;
            chk("full_stall", CmdReady, 0);
        end
        push(fv[5], 1'b1);
        wait_idle();
        chk("full_final", {ExpData, OutData, Mismatch}, {8'h84, 8'h84, 1'b0});

        // HOLD with length 0 issues exactly one cycle.
        push(mk(2'b00, 8'h00, 8'd0, 0, 0, 1, 8'h80, 8'h84, 0), 1'b1);
        @(posedge Clk); #1;
        chk("hold0_issue", {Done, Enable, Load}, 3'b100);
        @(posedge Clk); #1;
        chk("hold0_end", {Done, Enable, Busy}, 0);
        chk("hold0_exp", ExpData, 8'h84);

        // Sticky mismatch from a forced counter value.
        push(mk(2'b01, 8'h32, 8'd0, 1, 1, 1, 8'h32, 8'h84, 1), 1'b1);
        wait_idle();
        chk("mm_pre", {ExpData, Mismatch}, {8'h32, 1'b0});
        force_en = 1'b1; force_val = 8'h33;
        @(posedge Clk); #1;
        chk("mm_set", Mismatch, 1);
        force_en = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("mm_sticky", Mismatch, 1);

        // Reset in the middle of a long UP with another command queued.
        push(mk(2'b10, 8'h00, 8'd200, 1, 0, 1, 8'h32, 8'h00, 200), 1'b0);
        push(mk(2'b00, 8'h00, 8'd5, 0, 0, 1, 8'h32, 8'h00, 0), 1'b0);
        repeat (10) @(posedge Clk);
        #1;
        chk("mid_up", {Enable, UpDown, Busy}, 3'b111);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("abort_outs", {Enable, Load, Done, Mismatch, Busy, CmdReady, ExpData}, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("abort_ready", {CmdReady, Busy}, 2'b10);
        repeat (3) @(posedge Clk);
        #1;
        chk("abort_flushed", {Busy, Enable, Done, Mismatch}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
